// File: rtl/cache_sim_pkg.sv
// Shared types and derived-width helpers for the set-associative cache statistics model.
// Holds the controller state encoding and replacement-policy codes.
package cache_sim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_FLUSH
  } state_e;

  localparam int POLICY_LRU  = 0;
  localparam int POLICY_FIFO = 1;

  function automatic int off_w(input int line_size);
    return $clog2(line_size);
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_size, input int num_sets);
    return addr_w - off_w(line_size) - idx_w(num_sets);
  endfunction

  function automatic int way_w(input int assoc);
    return (assoc > 1) ? $clog2(assoc) : 1;
  endfunction

endpackage

// File: rtl/cache_repl_rank.sv
// Per-set victim choice and rank permutation update; purely combinational.
// Rank 0 is the next victim, rank ASSOC-1 the most recently promoted way.
module cache_repl_rank
  import cache_sim_pkg::*;
#(
  parameter int ASSOC  = 8,
  parameter int POLICY = POLICY_LRU,
  localparam int WAY_W = way_w(ASSOC)
) (
  input  logic [ASSOC-1:0]            valid_i,
  input  logic [ASSOC-1:0][WAY_W-1:0] rank_i,
  input  logic [WAY_W-1:0]            access_way_i,
  input  logic                        fill_i,
  output logic [WAY_W-1:0]            victim_o,
  output logic [ASSOC-1:0][WAY_W-1:0] rank_o
);

  logic             have_invalid;
  logic [WAY_W-1:0] old_rank;

  assign old_rank = rank_i[access_way_i];

  // Descending scan so the lowest-numbered candidate is the one left standing.
  always_comb begin
    victim_o     = '0;
    have_invalid = 1'b0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_o     = WAY_W'(w);
        have_invalid = 1'b1;
      end
    end
    if (!have_invalid) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (rank_i[w] == '0) victim_o = WAY_W'(w);
      end
    end
  end

  always_comb begin
    rank_o = rank_i;
    if (POLICY == POLICY_LRU || fill_i) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (WAY_W'(w) == access_way_i) rank_o[w] = WAY_W'(ASSOC - 1);
        else if (rank_i[w] > old_rank) rank_o[w] = rank_i[w] - WAY_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_sa_stats.sv
// Tag-only set-associative cache model counting hits, misses and writebacks.
// One access per 3 cycles (accept, lookup, update); flush sweeps one set per cycle.
module cache_sa_stats
  import cache_sim_pkg::*;
#(
  parameter int ADDR_W    = 31,
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 256,
  parameter int ASSOC     = 8,
  parameter int POLICY    = POLICY_LRU,
  parameter int CNT_W     = 31
) (
  input  logic                       clk_41,
  input  logic                       rst_41,
  input  logic                       req_valid_41,
  output logic                       req_ready_41,
  input  logic [ADDR_W-1:0]          req_addr_41,
  input  logic                       req_we_41,
  input  logic                       flush_41,
  output logic                       resp_valid_41,
  output logic                       resp_hit_41,
  output logic [way_w(ASSOC)-1:0]    resp_way_41,
  output logic [CNT_W-1:0]           hits_41,
  output logic [CNT_W-1:0]           misses_41,
  output logic [CNT_W-1:0]           writebacks_41,
  output logic                       busy_41
);

  localparam int OFF_W  = off_w(LINE_SIZE);
  localparam int IDX_W  = idx_w(NUM_SETS);
  localparam int IDX_SW = (IDX_W > 0) ? IDX_W : 1;
  localparam int TAG_W  = tag_w(ADDR_W, LINE_SIZE, NUM_SETS);
  localparam int WAY_W  = way_w(ASSOC);
  localparam int SUM_W  = CNT_W + 7;

  state_e                      state_q;
  logic [IDX_SW-1:0]           idx_q, flush_idx_q;
  logic [TAG_W-1:0]            tag_q;
  logic                        we_q, hit_q;
  logic [WAY_W-1:0]            way_q;
  logic [ASSOC-1:0]            valid_q [NUM_SETS];
  logic [ASSOC-1:0]            dirty_q [NUM_SETS];
  logic [ASSOC-1:0][TAG_W-1:0] tags_q  [NUM_SETS];
  logic [ASSOC-1:0][WAY_W-1:0] rank_q  [NUM_SETS];
  logic [CNT_W-1:0]            hits_q, misses_q, wb_q;
  logic                        resp_valid_q, resp_hit_q, busy_q;
  logic [WAY_W-1:0]            resp_way_q;

  logic [ADDR_W-1:0]           line_addr;
  logic [IDX_SW-1:0]           req_idx;
  logic [TAG_W-1:0]            req_tag;
  logic                        hit_d;
  logic [WAY_W-1:0]            hit_way_d, victim_d, sel_way_d;
  logic [ASSOC-1:0][WAY_W-1:0] rank_upd_d;
  logic [5:0]                  ndirty_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) return '1;
    return CNT_W'(s);
  endfunction

  assign line_addr = req_addr_41 >> OFF_W;
  assign req_idx   = IDX_SW'(line_addr) & IDX_SW'(NUM_SETS - 1);
  assign req_tag   = TAG_W'(line_addr >> IDX_W);

  always_comb begin
    hit_d     = 1'b0;
    hit_way_d = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (valid_q[idx_q][w] && tags_q[idx_q][w] == tag_q) begin
        hit_d     = 1'b1;
        hit_way_d = WAY_W'(w);
      end
    end
  end

  assign sel_way_d = hit_d ? hit_way_d : victim_d;

  always_comb begin
    ndirty_d = '0;
    for (int w = 0; w < ASSOC; w++)
      ndirty_d = ndirty_d + 6'(valid_q[flush_idx_q][w] & dirty_q[flush_idx_q][w]);
  end

  // The indexed set is stable from LOOKUP through UPDATE, so one instance serves both.
  cache_repl_rank #(
    .ASSOC  (ASSOC),
    .POLICY (POLICY)
  ) u_repl (
    .valid_i      (valid_q[idx_q]),
    .rank_i       (rank_q[idx_q]),
    .access_way_i (way_q),
    .fill_i       (!hit_q),
    .victim_o     (victim_d),
    .rank_o       (rank_upd_d)
  );

  always_ff @(posedge clk_41) begin
    if (rst_41) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      flush_idx_q  <= '0;
      tag_q        <= '0;
      we_q         <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      wb_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
      busy_q       <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < ASSOC; w++) rank_q[s][w] <= WAY_W'(w);
      end
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_41) begin
            state_q     <= ST_FLUSH;
            flush_idx_q <= '0;
            busy_q      <= 1'b1;
          end else if (req_valid_41) begin
            state_q <= ST_LOOKUP;
            idx_q   <= req_idx;
            tag_q   <= req_tag;
            we_q    <= req_we_41;
          end
        end
        ST_LOOKUP: begin
          hit_q        <= hit_d;
          way_q        <= sel_way_d;
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit_d;
          resp_way_q   <= sel_way_d;
          if (hit_d) begin
            hits_q <= sat_add(hits_q, 6'd1);
          end else begin
            misses_q <= sat_add(misses_q, 6'd1);
            if (valid_q[idx_q][victim_d] && dirty_q[idx_q][victim_d]) wb_q <= sat_add(wb_q, 6'd1);
          end
          state_q <= ST_UPDATE;
        end
        ST_UPDATE: begin
          valid_q[idx_q][way_q] <= 1'b1;
          tags_q[idx_q][way_q]  <= tag_q;
          if (we_q) dirty_q[idx_q][way_q] <= 1'b1;
          else if (!hit_q) dirty_q[idx_q][way_q] <= 1'b0;
          rank_q[idx_q] <= rank_upd_d;
          state_q       <= ST_IDLE;
        end
        ST_FLUSH: begin
          wb_q                 <= sat_add(wb_q, ndirty_d);
          valid_q[flush_idx_q] <= '0;
          dirty_q[flush_idx_q] <= '0;
          for (int w = 0; w < ASSOC; w++) rank_q[flush_idx_q][w] <= WAY_W'(w);
          if (flush_idx_q == IDX_SW'(NUM_SETS - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            flush_idx_q <= flush_idx_q + IDX_SW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_41  = (state_q == ST_IDLE) && !flush_41;
  assign resp_valid_41 = resp_valid_q;
  assign resp_hit_41   = resp_hit_q;
  assign resp_way_41   = resp_way_q;
  assign hits_41       = hits_q;
  assign misses_41     = misses_q;
  assign writebacks_41 = wb_q;
  assign busy_41       = busy_q;

endmodule

// File: tb/tb_cache_sa_stats.sv
// Three differently configured instances share one stimulus stream and are
// compared against a recency/fill-time reference model of the cache.
module tb_cache_sa_stats;
  localparam int AW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, req_we, flush;
  logic [AW-1:0] req_addr;

  logic       rdy0, rdy1, rdy2, rv0, rv1, rv2, rh0, rh1, rh2, bz0, bz1, bz2;
  logic [1:0] way0;
  logic       way1, way2;
  logic [7:0] h0, m0, w0, h1, m1, w1;
  logic [2:0] h2, m2, w2;

  cache_sa_stats #(.ADDR_W(AW), .LINE_SIZE(16), .NUM_SETS(4), .ASSOC(4), .POLICY(0), .CNT_W(8)) u_dut0 (
    .clk_41(clk), .rst_41(rst), .req_valid_41(req_valid), .req_ready_41(rdy0),
    .req_addr_41(req_addr), .req_we_41(req_we), .flush_41(flush),
    .resp_valid_41(rv0), .resp_hit_41(rh0), .resp_way_41(way0),
    .hits_41(h0), .misses_41(m0), .writebacks_41(w0), .busy_41(bz0));

  cache_sa_stats #(.ADDR_W(AW), .LINE_SIZE(16), .NUM_SETS(1), .ASSOC(2), .POLICY(0), .CNT_W(8)) u_dut1 (
    .clk_41(clk), .rst_41(rst), .req_valid_41(req_valid), .req_ready_41(rdy1),
    .req_addr_41(req_addr), .req_we_41(req_we), .flush_41(flush),
    .resp_valid_41(rv1), .resp_hit_41(rh1), .resp_way_41(way1),
    .hits_41(h1), .misses_41(m1), .writebacks_41(w1), .busy_41(bz1));

  cache_sa_stats #(.ADDR_W(AW), .LINE_SIZE(16), .NUM_SETS(1), .ASSOC(2), .POLICY(1), .CNT_W(3)) u_dut2 (
    .clk_41(clk), .rst_41(rst), .req_valid_41(req_valid), .req_ready_41(rdy2),
    .req_addr_41(req_addr), .req_we_41(req_we), .flush_41(flush),
    .resp_valid_41(rv2), .resp_hit_41(rh2), .resp_way_41(way2),
    .hits_41(h2), .misses_41(m2), .writebacks_41(w2), .busy_41(bz2));

  int o_rdy[3], o_rv[3], o_hit[3], o_way[3], o_hits[3], o_miss[3], o_wb[3], o_busy[3];
  always_comb begin
    o_rdy[0] = int'(rdy0);  o_rdy[1] = int'(rdy1);  o_rdy[2] = int'(rdy2);
    o_rv[0]  = int'(rv0);   o_rv[1]  = int'(rv1);   o_rv[2]  = int'(rv2);
    o_hit[0] = int'(rh0);   o_hit[1] = int'(rh1);   o_hit[2] = int'(rh2);
    o_way[0] = int'(way0);  o_way[1] = int'(way1);  o_way[2] = int'(way2);
    o_hits[0] = int'(h0);   o_hits[1] = int'(h1);   o_hits[2] = int'(h2);
    o_miss[0] = int'(m0);   o_miss[1] = int'(m1);   o_miss[2] = int'(m2);
    o_wb[0]   = int'(w0);   o_wb[1]   = int'(w1);   o_wb[2]   = int'(w2);
    o_busy[0] = int'(bz0);  o_busy[1] = int'(bz1);  o_busy[2] = int'(bz2);
  end

  // Per-instance configuration and reference model state.
  int n_sets[3]   = '{4, 1, 1};
  int set_bits[3] = '{2, 0, 0};
  int n_ways[3]   = '{4, 2, 2};
  int is_fifo[3]  = '{0, 0, 1};
  int cnt_max[3]  = '{255, 255, 7};

  bit mv[3][4][4];
  bit md[3][4][4];
  int mt[3][4][4];
  int mstamp[3][4][4];
  int e_hits[3], e_miss[3], e_wb[3];
  int now;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int i);
    return (v > cnt_max[i]) ? cnt_max[i] : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      e_hits[i] = 0; e_miss[i] = 0; e_wb[i] = 0;
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 4; w++) begin
          mv[i][s][w] = 1'b0; md[i][s][w] = 1'b0; mt[i][s][w] = 0; mstamp[i][s][w] = 0;
        end
    end
  endtask

  task automatic check_counters(input string where);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.hits[%0d]", where, i), o_hits[i], sat(e_hits[i], i));
      chk($sformatf("%s.misses[%0d]", where, i), o_miss[i], sat(e_miss[i], i));
      chk($sformatf("%s.wb[%0d]", where, i), o_wb[i], sat(e_wb[i], i));
    end
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 100; c++) begin
      if (o_rdy[0] == 1 && o_rdy[1] == 1 && o_rdy[2] == 1) return;
      @(negedge clk);
    end
    chk("ready_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst.ready[%0d]", i), o_rdy[i], 1);
      chk($sformatf("rst.resp_valid[%0d]", i), o_rv[i], 0);
      chk($sformatf("rst.busy[%0d]", i), o_busy[i], 0);
    end
    check_counters("rst");
  endtask

  task automatic access(input int addr, input bit we);
    int exp_hit[3], exp_way[3];
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      int s, tg, hw, vic, best;
      s  = (addr >> 4) % n_sets[i];
      tg = addr >> (4 + set_bits[i]);
      hw = -1;
      for (int w = n_ways[i] - 1; w >= 0; w--)
        if (mv[i][s][w] && mt[i][s][w] == tg) hw = w;
      if (hw >= 0) begin
        exp_hit[i] = 1; exp_way[i] = hw; e_hits[i]++;
        if (is_fifo[i] == 0) mstamp[i][s][hw] = now;
        if (we) md[i][s][hw] = 1'b1;
      end else begin
        vic = -1;
        for (int w = n_ways[i] - 1; w >= 0; w--) if (!mv[i][s][w]) vic = w;
        if (vic < 0) begin
          best = 0;
          for (int w = 1; w < n_ways[i]; w++) if (mstamp[i][s][w] < mstamp[i][s][best]) best = w;
          vic = best;
        end
        exp_hit[i] = 0; exp_way[i] = vic; e_miss[i]++;
        if (mv[i][s][vic] && md[i][s][vic]) e_wb[i]++;
        mv[i][s][vic] = 1'b1; md[i][s][vic] = we; mt[i][s][vic] = tg; mstamp[i][s][vic] = now;
      end
    end
    now++;
    req_valid = 1'b1; req_addr = AW'(addr); req_we = we;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("early_resp[%0d]", i), o_rv[i], 0);
      chk($sformatf("busy_ready[%0d]", i), o_rdy[i], 0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("resp_valid[%0d] a=%0h", i, addr), o_rv[i], 1);
      chk($sformatf("resp_hit[%0d] a=%0h", i, addr), o_hit[i], exp_hit[i]);
      chk($sformatf("resp_way[%0d] a=%0h", i, addr), o_way[i], exp_way[i]);
    end
    check_counters("acc");
    @(negedge clk);
  endtask

  task automatic do_flush();
    int cnt[3];
    wait_ready();
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 3; i++) if (o_busy[i] == 1) cnt[i]++;
      if (o_busy[0] == 0 && o_busy[1] == 0 && o_busy[2] == 0) break;
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush.busy_cycles[%0d]", i), cnt[i], n_sets[i]);
      for (int s = 0; s < 4; s++)
        for (int w = 0; w < 4; w++) begin
          if (mv[i][s][w] && md[i][s][w]) e_wb[i]++;
          mv[i][s][w] = 1'b0; md[i][s][w] = 1'b0;
        end
    end
    check_counters("flush");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; flush = 1'b0;
    now = 0;
    do_reset();

    // Cold read then same-line hit.
    access('h100, 1'b0);
    access('h104, 1'b0);

    // Eviction order differs between recency and fill-order replacement.
    do_reset();
    access('h000, 1'b0); access('h010, 1'b0); access('h000, 1'b0);
    access('h020, 1'b0); access('h000, 1'b0); access('h010, 1'b0);

    // Dirty line pushed out by further distinct tags in the same set.
    do_reset();
    access('h000, 1'b1);
    for (int k = 1; k <= 4; k++) access(k * 'h1000, 1'b0);

    // Flush writes back dirty lines and invalidates everything.
    do_reset();
    access('h000, 1'b1); access('h010, 1'b1); access('h120, 1'b1);
    do_flush();
    access('h000, 1'b0); access('h010, 1'b0); access('h120, 1'b0);

    // Nine misses saturate the 3-bit counters.
    do_reset();
    for (int k = 1; k <= 9; k++) access(k * 'h100, 1'b0);

    // Randomized traffic over a small line pool, with occasional flushes.
    do_reset();
    begin
      int addr;
      addr = 0;
      for (int n = 0; n < 160; n++) begin
        if ($urandom_range(0, 24) == 0) begin
          do_flush();
        end else begin
          if ($urandom_range(0, 2) != 0)
            addr = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15);
          access(addr, ($urandom_range(0, 2) == 0));
        end
      end
    end

    // Reset during LOOKUP abandons the access.
    wait_ready();
    req_valid = 1'b1; req_addr = AW'('h300); req_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) chk($sformatf("abandon.resp_valid[%0d]", i), o_rv[i], 0);
      @(negedge clk);
    end
    check_counters("abandon");
    access('h300, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_sa_stats.md
CACHE_SA_STATS -- requirements
Module: cache_sa_stats

Interface
REQ-001 Parameter ADDR_W, default 31: request address width in bits.
REQ-002 Parameter LINE_SIZE, default 16: line size in bytes, power of two.
REQ-003 Parameter NUM_SETS, default 256: number of sets, power of two, at least 1.
REQ-004 Parameter ASSOC, default 8: ways per set, power of two, 1 to 32.
REQ-005 Parameter POLICY, default 0: replacement policy, 0 = LRU, 1 = FIFO.
REQ-006 Parameter CNT_W, default 31: width of the statistics counters.
REQ-007 clk_41  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_41  input  1  reset, synchronous and active-high.
REQ-009 req_valid_41  input  1  access request valid.
REQ-010 req_ready_41  output  1  block can accept a request.
REQ-011 req_addr_41  input  ADDR_W  byte address.
REQ-012 req_we_41  input  1  1 = write access, 0 = read access.
REQ-013 flush_41  input  1  pulse requesting invalidation of the whole cache.
REQ-014 resp_valid_41  output  1  one-cycle pulse that completes an access.
REQ-015 resp_hit_41  output  1  hit flag, qualified by resp_valid_41.
REQ-016 resp_way_41  output  log2(ASSOC) (min 1)  way hit or filled.
REQ-017 hits_41, misses_41, writebacks_41  output  CNT_W each  statistics counters.
REQ-018 busy_41  output  1  high while a flush is in progress.

Function
REQ-019 Address decode: offset = low log2(LINE_SIZE) bits; index = next log2(NUM_SETS) bits; tag = the remaining upper bits.
REQ-020 Per line, store: valid bit, dirty bit, tag, and a rank of log2(ASSOC) bits.
REQ-021 FSM states: IDLE, LOOKUP, UPDATE, FLUSH.
REQ-022 req_ready_41 = 1 only in IDLE with flush_41 low.
REQ-023 A request is accepted when req_valid_41 and req_ready_41 are both high; its address and we are registered and the FSM moves to LOOKUP.
REQ-024 LOOKUP compares the registered tag against all ASSOC ways of the indexed set in one cycle.
REQ-025 A hit requires valid and an equal tag; if more than one way matches, the lowest-numbered way wins.
REQ-026 On a miss, choose the victim as the lowest-numbered invalid way; if none is invalid, choose the way with rank 0.
REQ-027 On a miss, if the victim is valid and dirty, increment writebacks_41.
REQ-028 UPDATE writes the line: valid = 1; tag = the request tag.
REQ-029 UPDATE sets dirty as follows:
 - write access: dirty = 1;
 - read miss: dirty = 0;
 - read hit: dirty unchanged.
REQ-030 UPDATE asserts resp_valid_41 for one cycle, then the FSM returns to IDLE.
REQ-031 Latency: resp_valid_41 occurs exactly 2 cycles after acceptance; the next request can be accepted 3 cycles after the previous acceptance.
REQ-032 LRU rank update (POLICY 0, on any access to way W with old rank R):
 - ways with rank greater than R decrement by 1;
 - W takes rank ASSOC-1.
REQ-033 FIFO rank update (POLICY 1): ranks change only on a fill, using the REQ-032 rule; hits leave ranks unchanged.
REQ-034 The ranks within each set always form a permutation of 0..ASSOC-1.
REQ-035 hits_41 increments on each hit and misses_41 on each miss.
REQ-036 All three counters saturate at all-ones and do not wrap.
REQ-037 flush_41 sampled high in IDLE moves the FSM to FLUSH; flush_41 in any other state is ignored.
REQ-038 FLUSH visits one set per cycle, indexes 0 to NUM_SETS-1, for NUM_SETS cycles.
REQ-039 For each set visited, FLUSH:
 - adds the number of valid dirty lines to writebacks_41 (saturating);
 - clears valid and dirty;
 - restores each rank to its way number.
REQ-040 busy_41 = 1 throughout FLUSH; the FSM returns to IDLE after the last set.
REQ-041 If flush_41 and req_valid_41 are both high in IDLE, the flush has priority and the request is not accepted.

Reset
REQ-042 rst_41 high at a clock edge sets: FSM to IDLE; all counters to 0; resp_valid_41, resp_hit_41, resp_way_41 and busy_41 to 0.
REQ-043 The same reset edge clears every valid and dirty bit and loads each rank with its way number.
REQ-044 Reset mid-LOOKUP, mid-UPDATE or mid-FLUSH abandons the operation: no response is issued and no counter is updated.
REQ-045 req_ready_41 = 1 on the first cycle after rst_41 deasserts.

Structure
REQ-046 The shared package cache_sim_pkg holds:
 - the FSM state enumeration;
 - the POLICY encodings;
 - derived-width constant functions (offset, index and tag widths).
REQ-047 The per-set victim selection and rank update shall be a sub-module named cache_repl_rank, parameterised by ASSOC and POLICY.

Verification
REQ-048 Cold read: reset, then a read at 0x0000100 gives resp_hit_41 = 0 and misses_41 = 1; reading 0x0000104 next gives resp_hit_41 = 1 and hits_41 = 1.
REQ-049 LRU eviction: ASSOC = 2, NUM_SETS = 1, LINE_SIZE = 16.
 - reads A = 0x000, B = 0x010, then A again, then C = 0x020;
 - C evicts B;
 - a following read of A hits and a read of B misses.
REQ-050 FIFO policy: same sequence as REQ-049 with POLICY = 1; C evicts A, and a read of A then misses.
REQ-051 Writeback count: write 0x000, then fill the set with ASSOC further distinct tags; writebacks_41 = 1 when the dirty line is evicted.
REQ-052 Flush: set 3 lines dirty, pulse flush_41, then check:
 - busy_41 stays high for NUM_SETS cycles;
 - writebacks_41 increases by 3;
 - a re-read of each of those addresses misses.
REQ-053 Saturation: CNT_W = 3; issue 9 misses; misses_41 holds at 7.
